// File: rtl/alu_stim_gen_if.sv
// ALU start/done handshake bus shared by the stimulus engine (master) and the ALU (slave).
interface alu_stim_gen_if #(
   parameter int unsigned DATA_W = 8
);
   logic                alu_start;
   logic [2:0]          alu_op;
   logic [DATA_W-1:0]   alu_A;
   logic [DATA_W-1:0]   alu_B;
   logic                alu_done;
   logic [2*DATA_W-1:0] alu_result;
   logic                alu_reset_n;

   modport master (
      output alu_start, alu_op, alu_A, alu_B, alu_reset_n,
      input  alu_done, alu_result
   );

   modport slave (
      input  alu_start, alu_op, alu_A, alu_B, alu_reset_n,
      output alu_done, alu_result
   );
endinterface

// File: rtl/alu_stim_gen.sv
// LFSR-driven weighted-random ALU stimulus engine with hang detection.
// Optional result checking is enabled by defining STIM_SCOREBOARD_EN.
module alu_stim_gen #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned NUM_TXN     = 1000,
   parameter logic [31:0] LFSR_SEED   = 32'h1,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned RST_CYC     = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           run_i,
   alu_stim_gen_if.master alu,
   output logic           busy,
   output logic           finished,
   output logic [15:0]    txn_count,
   output logic           timeout_err
`ifdef STIM_SCOREBOARD_EN
   ,
   output logic [15:0]    mismatch_count,
   output logic           mismatch_o
`endif
);

   localparam logic [31:0] SEED      = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] TAP_MASK  = 32'h8020_0003;
   localparam logic [15:0] NUM_TXN_C = 16'(NUM_TXN);
   localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYC);
   localparam logic [15:0] RST_LIM   = 16'(RST_CYC);

   typedef enum logic [2:0] {
      OP_NO  = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100,
      OP_RST = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_ISSUE,
      S_WAIT_DONE,
      S_RESET_DUT,
      S_FINISHED
   } state_e;

   state_e              state_q;
   logic [31:0]         lfsr_q, lfsr_d;
   op_e                 op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                start_q, alu_rst_n_q, busy_q, fin_q, tmo_q;
   logic [15:0]         txn_q, cnt_q;

   function automatic logic [DATA_W-1:0] pick(input logic [1:0] cls, input logic [DATA_W-1:0] rnd);
      case (cls)
         2'b00:   return '0;
         2'b11:   return '1;
         default: return rnd;
      endcase
   endfunction

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAP_MASK : '0);
      op_d   = OP_NO;
      case (lfsr_q[2:0])
         3'b001:        op_d = OP_ADD;
         3'b010:        op_d = OP_AND;
         3'b011:        op_d = OP_XOR;
         3'b100:        op_d = OP_MUL;
         3'b110, 3'b111: op_d = OP_RST;
         default:       op_d = OP_NO;
      endcase
      a_d = pick(lfsr_q[4:3], lfsr_q[8 +: DATA_W]);
      b_d = pick(lfsr_q[6:5], lfsr_q[20 +: DATA_W]);
   end

`ifdef STIM_SCOREBOARD_EN
   logic [2*DATA_W-1:0] expect_d;
   logic [15:0]         mm_cnt_q;
   logic                mm_q;

   always_comb begin
      expect_d = '0;
      case (op_q)
         OP_ADD:  expect_d = {{DATA_W{1'b0}}, a_q} + {{DATA_W{1'b0}}, b_q};
         OP_AND:  expect_d = {{DATA_W{1'b0}}, a_q & b_q};
         OP_XOR:  expect_d = {{DATA_W{1'b0}}, a_q ^ b_q};
         OP_MUL:  expect_d = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
         default: expect_d = '0;
      endcase
   end
`else
   logic unused_result;
   assign unused_result = ^alu.alu_result;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         lfsr_q      <= SEED;
         op_q        <= OP_NO;
         a_q         <= '0;
         b_q         <= '0;
         start_q     <= 1'b0;
         alu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         fin_q       <= 1'b0;
         tmo_q       <= 1'b0;
         txn_q       <= '0;
         cnt_q       <= '0;
`ifdef STIM_SCOREBOARD_EN
         mm_cnt_q    <= '0;
         mm_q        <= 1'b0;
`endif
      end else begin
`ifdef STIM_SCOREBOARD_EN
         mm_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               alu_rst_n_q <= 1'b1;
               if (run_i) begin
                  state_q <= S_GEN;
                  busy_q  <= 1'b1;
               end
            end
            S_GEN: begin
               if (txn_q == NUM_TXN_C) begin
                  state_q <= S_FINISHED;
                  busy_q  <= 1'b0;
                  fin_q   <= 1'b1;
               end else if (run_i) begin
                  lfsr_q <= lfsr_d;
                  op_q   <= op_d;
                  a_q    <= a_d;
                  b_q    <= b_d;
                  cnt_q  <= 16'd1;
                  if (txn_q != '1) txn_q <= txn_q + 1'b1;
                  if (op_d == OP_RST) begin
                     alu_rst_n_q <= 1'b0;
                     state_q     <= S_RESET_DUT;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end
            end
            // cnt_q holds the number of cycles alu_start has been high, ISSUE included
            S_ISSUE, S_WAIT_DONE: begin
               if ((state_q == S_ISSUE && op_q == OP_NO) || alu.alu_done) begin
                  start_q <= 1'b0;
                  state_q <= S_GEN;
`ifdef STIM_SCOREBOARD_EN
                  if (alu.alu_done && op_q != OP_NO && alu.alu_result != expect_d) begin
                     mm_q <= 1'b1;
                     if (mm_cnt_q != '1) mm_cnt_q <= mm_cnt_q + 1'b1;
                  end
`endif
               end else if (cnt_q >= TO_LIM) begin
                  start_q <= 1'b0;
                  tmo_q   <= 1'b1;
                  fin_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISHED;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= S_WAIT_DONE;
               end
            end
            S_RESET_DUT: begin
               if (cnt_q >= RST_LIM) begin
                  alu_rst_n_q <= 1'b1;
                  state_q     <= S_GEN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FINISHED: state_q <= S_FINISHED;
            default:    state_q <= S_IDLE;
         endcase
      end
   end

   assign alu.alu_start   = start_q;
   assign alu.alu_op      = op_q;
   assign alu.alu_A       = a_q;
   assign alu.alu_B       = b_q;
   assign alu.alu_reset_n = alu_rst_n_q;
   assign busy            = busy_q;
   assign finished        = fin_q;
   assign txn_count       = txn_q;
   assign timeout_err     = tmo_q;
`ifdef STIM_SCOREBOARD_EN
   assign mismatch_count  = mm_cnt_q;
   assign mismatch_o      = mm_q;
`endif

endmodule

// File: tb/tb_alu_stim_gen.sv
// Bench for alu_stim_gen: a responder ALU, an LFSR reference queue and an issue monitor.
`timescale 1ns/1ps
module tb_alu_stim_gen;
   localparam int unsigned DW   = 8;
   localparam int unsigned NTXN = 40;
   localparam logic [31:0] SEED = 32'h1;
   localparam int unsigned TMO  = 16;
   localparam int unsigned RSTC = 2;

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int unsigned   idx;
   } txn_t;

   logic        clk;
   logic        reset_n;
   logic        run_i;
   logic        busy;
   logic        finished;
   logic        timeout_err;
   logic [15:0] txn_count;
`ifdef STIM_SCOREBOARD_EN
   logic [15:0] mismatch_count;
   logic        mismatch_o;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;
   bit          hang   = 0;
   txn_t        exp_q[$];

   alu_stim_gen_if #(.DATA_W(DW)) bus ();

   alu_stim_gen #(
      .DATA_W(DW), .NUM_TXN(NTXN), .LFSR_SEED(SEED), .TIMEOUT_CYC(TMO), .RST_CYC(RSTC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .run_i(run_i), .alu(bus),
      .busy(busy), .finished(finished), .txn_count(txn_count), .timeout_err(timeout_err)
`ifdef STIM_SCOREBOARD_EN
      , .mismatch_count(mismatch_count), .mismatch_o(mismatch_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [DW-1:0] operand(input int unsigned cls, input logic [31:0] raw);
      if (cls == 0) return '0;
      if (cls == 3) return DW'((64'd1 << DW) - 1);
      return DW'(raw % (32'd1 << DW));
   endfunction

   function automatic logic [2*DW-1:0] alu_calc(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] x, y;
      x = a;
      y = b;
      case (op)
         3'd1:    return x + y;
         3'd2:    return x & y;
         3'd3:    return x ^ y;
         3'd4:    return x * y;
         default: return '0;
      endcase
   endfunction

   // Full expected transaction sequence of one run from the seed.
   task automatic load_model();
      logic [31:0] l;
      int unsigned opmap [8] = '{0, 1, 2, 3, 4, 0, 7, 7};
      l = (SEED == 32'h0) ? 32'h1 : SEED;
      exp_q.delete();
      for (int unsigned k = 1; k <= NTXN; k++) begin
         txn_t t;
         t.op  = 3'(opmap[l % 8]);
         t.a   = operand((l >> 3) % 4, l >> 8);
         t.b   = operand((l >> 5) % 4, l >> 20);
         t.idx = k;
         exp_q.push_back(t);
         l = lfsr_step(l);
      end
   endtask

   // ALU responder: done three cycles after a real op is first seen.
   int unsigned resp_cnt  = 0;
   bit          resp_busy = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         resp_busy      = 0;
         bus.alu_done   = 1'b0;
         bus.alu_result = '0;
      end else if (bus.alu_done) begin
         bus.alu_done = 1'b0;
         resp_busy    = 0;
      end else if (resp_busy) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = alu_calc(bus.alu_op, bus.alu_A, bus.alu_B);
         end
      end else if (!hang && bus.alu_start && bus.alu_op != 3'd0) begin
         resp_busy = 1;
         resp_cnt  = 3;
      end
   end

   task automatic expect_event(input bit is_issue);
      txn_t t;
      if (exp_q.size() == 0) begin
         check(is_issue ? "unexpected_issue" : "unexpected_alu_reset", 1, 0);
         return;
      end
      t = exp_q.pop_front();
      check(is_issue ? "issue_op" : "reset_op", bus.alu_op, t.op);
      if (is_issue) begin
         check("issue_A", bus.alu_A, t.a);
         check("issue_B", bus.alu_B, t.b);
      end
      check("event_txn_count", txn_count, t.idx);
   endtask

   bit prev_start = 0;
   bit prev_rstn  = 0;
   always @(negedge clk) begin
      if (reset_n && busy) begin
         if (bus.alu_start && !prev_start) expect_event(1'b1);
         if (!bus.alu_reset_n && prev_rstn) expect_event(1'b0);
      end
      prev_start = bus.alu_start;
      prev_rstn  = bus.alu_reset_n;
   end

   task automatic do_reset();
      @(posedge clk);
      #1 reset_n = 1'b0;
      load_model();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_finished(input string tag);
      int unsigned n = 0;
      while (!finished && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_finish_within_budget"}, n < 3000, 1);
   endtask

   initial begin
      int unsigned n;
      int unsigned viol;
      int unsigned c0;
      int unsigned c1;
      logic [15:0] frozen;
      bit          prev;
      bit          hit;

      reset_n = 1'b0;
      run_i   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_alu_start", bus.alu_start, 0);
      check("rst_alu_reset_n", bus.alu_reset_n, 0);
      check("rst_alu_op", bus.alu_op, 0);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_txn_count", txn_count, 0);
      check("rst_timeout_err", timeout_err, 0);

      // Run with a pause in the middle.
      load_model();
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_i = 1'b1;
      n = 0;
      while (txn_count < 10 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reach_10_txn", n < 500, 1);
      @(posedge clk);
      #1 run_i = 1'b0;
      repeat (8) @(negedge clk);
      frozen = txn_count;
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.alu_start || txn_count != frozen) viol++;
      end
      check("pause_violations", viol, 0);
      check("pause_busy", busy, 1);
      @(posedge clk);
      #1 run_i = 1'b1;
      wait_finished("run");
      @(negedge clk);
      check("run_finished", finished, 1);
      check("run_busy", busy, 0);
      check("run_alu_start", bus.alu_start, 0);
      check("run_txn_count", txn_count, NTXN);
      check("run_timeout_err", timeout_err, 0);
      check("run_expected_left", exp_q.size(), 0);
`ifdef STIM_SCOREBOARD_EN
      check("run_mismatch_count", mismatch_count, 0);
`endif

      // Reset pulse during WAIT_DONE, then replay from the same seed.
      do_reset();
      n = 0;
      prev = 0;
      hit = 0;
      while (!hit && n < 1000) begin
         @(negedge clk);
         hit  = bus.alu_start && prev && txn_count >= 3;
         prev = bus.alu_start;
         n++;
      end
      check("found_wait_done", hit, 1);
      reset_n = 1'b0;
      @(posedge clk);
      load_model();
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("midrst_alu_start", bus.alu_start, 0);
      check("midrst_alu_reset_n", bus.alu_reset_n, 0);
      check("midrst_txn_count", txn_count, 0);
      check("midrst_busy", busy, 0);
      wait_finished("replay");
      @(negedge clk);
      check("replay_txn_count", txn_count, NTXN);
      check("replay_expected_left", exp_q.size(), 0);

      // Hung ALU: first op of this seed is a real op, so it must time out.
      hang = 1;
      do_reset();
      n = 0;
      while (!bus.alu_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hang_first_start_seen", bus.alu_start, 1);
      c0 = cyc;
      n = 0;
      while (!timeout_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      c1 = cyc;
      check("timeout_err_set", timeout_err, 1);
      check("timeout_latency", c1 - c0, TMO);
      check("timeout_finished", finished, 1);
      check("timeout_alu_start", bus.alu_start, 0);
      check("timeout_busy", busy, 0);
      check("timeout_txn_count", txn_count, 1);
      repeat (5) @(negedge clk);
      check("timeout_sticky", timeout_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
